// File: rtl/tetris_engine_if.sv
// Board-memory port between the engine and the playfield RAM.
// The read side is combinational, and writes commit on the clock edge.
interface tetris_engine_if #(
  parameter int XW = 4,
  parameter int YW = 5
);
  logic [XW-1:0] board_rx;
  logic [YW-1:0] board_ry;
  logic          board_rdata;
  logic          board_we;
  logic [XW-1:0] board_wx;
  logic [YW-1:0] board_wy;
  logic          board_wdata;

  modport master (
    output board_rx, board_ry, board_we, board_wx, board_wy, board_wdata,
    input  board_rdata
  );

  modport slave (
    input  board_rx, board_ry, board_we, board_wx, board_wy, board_wdata,
    output board_rdata
  );
endinterface

// File: rtl/tetris_engine.sv
// Tetris game engine: spawn, move/rotate with collision checks, lock,
// line clear with board shift, and game over. Includes the shape offset table.
module tetris_piece_offsets (
  input  logic [2:0]  i_shape,
  input  logic [1:0]  i_rot,
  output logic [15:0] o_dx,
  output logic [15:0] o_dy
);
  logic [15:0] w_bx;
  logic [15:0] w_by;
  logic [1:0]  w_rot;

  // Base pose: block i lives in bits [4i+3:4i], and -1 is encoded as 4'hF.
  always_comb begin
    w_bx = '0;
    w_by = '0;
    case (i_shape)
      3'd1: begin w_bx = 16'h210F; w_by = 16'h0000; end
      3'd2: begin w_bx = 16'h010F; w_by = 16'h1000; end
      3'd3: begin w_bx = 16'h0F10; w_by = 16'h1100; end
      3'd4: begin w_bx = 16'h1010; w_by = 16'h1100; end
      3'd5: begin w_bx = 16'h100F; w_by = 16'h1100; end
      3'd6: begin w_bx = 16'h110F; w_by = 16'h1000; end
      3'd7: begin w_bx = 16'hF10F; w_by = 16'h1000; end
      default: begin w_bx = '0; w_by = '0; end
    endcase
  end

  assign w_rot = (i_shape == 3'd4) ? 2'd0 : i_rot;

  always_comb begin
    logic signed [3:0] v_x;
    logic signed [3:0] v_y;
    o_dx = '0;
    o_dy = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      v_x = w_bx[4*i +: 4];
      v_y = w_by[4*i +: 4];
      case (w_rot)
        2'd1:    begin o_dx[4*i +: 4] = -v_y; o_dy[4*i +: 4] =  v_x; end
        2'd2:    begin o_dx[4*i +: 4] = -v_x; o_dy[4*i +: 4] = -v_y; end
        2'd3:    begin o_dx[4*i +: 4] =  v_y; o_dy[4*i +: 4] = -v_x; end
        default: begin o_dx[4*i +: 4] =  v_x; o_dy[4*i +: 4] =  v_y; end
      endcase
    end
  end
endmodule

module tetris_engine #(
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 20,
  parameter int XW         = 4,
  parameter int YW         = 5,
  parameter int NUM_SHAPES = 7,
  parameter int SCORE_W    = 8
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               left_final,
  input  logic               right_final,
  input  logic               rot_final,
  input  logic               tick_gravity,
  tetris_engine_if.master    board,
  output logic [XW-1:0]      piece_x,
  output logic [YW-1:0]      piece_y,
  output logic [1:0]         rot,
  output logic [2:0]         shape_id,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               move_accept,
  output logic               busy
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SPAWN = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_FALL  = 3'd3;
  localparam logic [2:0] S_LOCK  = 3'd4;
  localparam logic [2:0] S_SCAN  = 3'd5;
  localparam logic [2:0] S_SHIFT = 3'd6;
  localparam logic [2:0] S_OVER  = 3'd7;

  localparam logic [1:0] O_SPAWN = 2'd0;
  localparam logic [1:0] O_MOVE  = 2'd1;
  localparam logic [1:0] O_GRAV  = 2'd2;

  localparam int TXW = XW + 2;
  localparam int TYW = YW + 2;
  localparam logic signed [TXW-1:0] C_W      = TXW'(BOARD_W);
  localparam logic signed [TYW-1:0] C_H      = TYW'(BOARD_H);
  localparam logic [XW-1:0]         C_XMAX   = XW'(BOARD_W - 1);
  localparam logic [YW-1:0]         C_YMAX   = YW'(BOARD_H - 1);
  localparam logic [XW-1:0]         C_XSPAWN = XW'(BOARD_W / 2 - 1);

  logic [2:0]         r_state;
  logic [XW-1:0]      r_piece_x;
  logic [YW-1:0]      r_piece_y;
  logic [1:0]         r_rot;
  logic [2:0]         r_shape;
  logic [SCORE_W-1:0] r_score;
  logic               r_move_accept;
  logic [2:0]         r_lfsr;
  logic signed [1:0]  r_dx;
  logic               r_dy;
  logic               r_drot;
  logic [1:0]         r_origin;
  logic [1:0]         r_idx;
  logic               r_coll;
  logic [YW-1:0]      r_row;
  logic [XW-1:0]      r_col;
  logic [XW-1:0]      r_sx;
  logic [YW-1:0]      r_sy;
  logic               r_clr;

  logic [15:0]          w_cur_dx, w_cur_dy, w_tri_dx, w_tri_dy;
  logic [1:0]           w_trot;
  logic signed [3:0]    w_cdx, w_cdy, w_tdx, w_tdy;
  logic signed [TXW-1:0] w_tx;
  logic signed [TYW-1:0] w_ty;
  logic                 w_oob, w_hit;
  logic [XW-1:0]        w_crx, w_lx;
  logic [YW-1:0]        w_cry, w_ly;
  logic [2:0]           w_spawn_shape;

  assign w_trot = r_rot + {1'b0, r_drot};

  tetris_piece_offsets u_cur (
    .i_shape (r_shape),
    .i_rot   (r_rot),
    .o_dx    (w_cur_dx),
    .o_dy    (w_cur_dy)
  );

  tetris_piece_offsets u_trial (
    .i_shape (r_shape),
    .i_rot   (w_trot),
    .o_dx    (w_tri_dx),
    .o_dy    (w_tri_dy)
  );

  assign w_cdx = w_cur_dx[{r_idx, 2'b00} +: 4];
  assign w_cdy = w_cur_dy[{r_idx, 2'b00} +: 4];
  assign w_tdx = w_tri_dx[{r_idx, 2'b00} +: 4];
  assign w_tdy = w_tri_dy[{r_idx, 2'b00} +: 4];

  assign w_tx = $signed({2'b00, r_piece_x}) + TXW'(r_dx) + TXW'(w_tdx);
  assign w_ty = $signed({2'b00, r_piece_y}) + TYW'({1'b0, r_dy}) + TYW'(w_tdy);

  assign w_oob = w_tx[TXW-1] || (w_tx >= C_W) || w_ty[TYW-1] || (w_ty >= C_H);
  assign w_hit = w_oob || board.board_rdata;

  // Out-of-range probes are clamped so the RAM is never addressed past the board.
  assign w_crx = w_tx[TXW-1] ? '0 : ((w_tx >= C_W) ? C_XMAX : w_tx[XW-1:0]);
  assign w_cry = w_ty[TYW-1] ? '0 : ((w_ty >= C_H) ? C_YMAX : w_ty[YW-1:0]);

  assign w_lx = r_piece_x + XW'(w_cdx);
  assign w_ly = r_piece_y + YW'(w_cdy);

  assign w_spawn_shape = 3'((32'(r_lfsr) % NUM_SHAPES) + 1);

  always_comb begin
    board.board_rx = '0;
    board.board_ry = '0;
    board.board_wx = '0;
    board.board_wy = '0;
    case (r_state)
      S_CHECK: begin
        board.board_rx = w_crx;
        board.board_ry = w_cry;
      end
      S_SCAN: begin
        board.board_rx = r_col;
        board.board_ry = r_row;
      end
      S_LOCK: begin
        board.board_wx = w_lx;
        board.board_wy = w_ly;
      end
      S_SHIFT: begin
        board.board_rx = r_sx;
        board.board_ry = r_clr ? '0 : (r_sy - 1'b1);
        board.board_wx = r_sx;
        board.board_wy = r_clr ? '0 : r_sy;
      end
      default: ;
    endcase
  end

  assign board.board_we    = resetn && ((r_state == S_LOCK) || (r_state == S_SHIFT));
  assign board.board_wdata = (r_state == S_LOCK) ||
                             ((r_state == S_SHIFT) && !r_clr && board.board_rdata);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_piece_x     <= '0;
      r_piece_y     <= '0;
      r_rot         <= '0;
      r_shape       <= 3'd1;
      r_score       <= '0;
      r_move_accept <= 1'b0;
      r_lfsr        <= 3'b001;
      r_dx          <= '0;
      r_dy          <= 1'b0;
      r_drot        <= 1'b0;
      r_origin      <= O_SPAWN;
      r_idx         <= '0;
      r_coll        <= 1'b0;
      r_row         <= '0;
      r_col         <= '0;
      r_sx          <= '0;
      r_sy          <= '0;
      r_clr         <= 1'b0;
    end else begin
      r_lfsr        <= {r_lfsr[1:0], r_lfsr[2] ^ r_lfsr[1]};
      r_move_accept <= 1'b0;
      case (r_state)
        // The spawn pose is loaded on entry, so it is visible during SPAWN.
        S_IDLE: begin
          r_shape   <= w_spawn_shape;
          r_rot     <= '0;
          r_piece_x <= C_XSPAWN;
          r_piece_y <= '0;
          r_state   <= S_SPAWN;
        end
        S_SPAWN: begin
          r_dx     <= '0;
          r_dy     <= 1'b0;
          r_drot   <= 1'b0;
          r_origin <= O_SPAWN;
          r_idx    <= '0;
          r_coll   <= 1'b0;
          r_state  <= S_CHECK;
        end
        S_FALL: begin
          r_idx  <= '0;
          r_coll <= 1'b0;
          r_dx   <= '0;
          r_dy   <= 1'b0;
          r_drot <= 1'b0;
          if (left_final) begin
            r_dx <= -2'sd1; r_origin <= O_MOVE; r_state <= S_CHECK;
          end else if (right_final) begin
            r_dx <= 2'sd1;  r_origin <= O_MOVE; r_state <= S_CHECK;
          end else if (rot_final) begin
            r_drot <= 1'b1; r_origin <= O_MOVE; r_state <= S_CHECK;
          end else if (tick_gravity) begin
            r_dy <= 1'b1;   r_origin <= O_GRAV; r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_idx != 2'd3) begin
            r_coll <= r_coll || w_hit;
            r_idx  <= r_idx + 2'd1;
          end else if (r_coll || w_hit) begin
            r_idx <= '0;
            case (r_origin)
              O_GRAV:  r_state <= S_LOCK;
              O_MOVE:  r_state <= S_FALL;
              default: r_state <= S_OVER;
            endcase
          end else begin
            if (r_origin != O_SPAWN) begin
              r_piece_x     <= r_piece_x + XW'(r_dx);
              r_piece_y     <= r_piece_y + YW'({1'b0, r_dy});
              r_rot         <= w_trot;
              r_move_accept <= 1'b1;
            end
            r_state <= S_FALL;
          end
        end
        S_LOCK: begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_row   <= C_YMAX;
            r_col   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!board.board_rdata) begin
            if (r_row == '0) begin
              r_shape   <= w_spawn_shape;
              r_rot     <= '0;
              r_piece_x <= C_XSPAWN;
              r_piece_y <= '0;
              r_state   <= S_SPAWN;
            end else begin
              r_row <= r_row - 1'b1;
              r_col <= '0;
            end
          end else if (r_col == C_XMAX) begin
            r_sx    <= '0;
            r_sy    <= r_row;
            r_clr   <= (r_row == '0);
            r_state <= S_SHIFT;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_sx != C_XMAX) begin
            r_sx <= r_sx + 1'b1;
          end else begin
            r_sx <= '0;
            if (r_clr) begin
              r_clr   <= 1'b0;
              r_col   <= '0;
              r_state <= S_SCAN;
              if (r_score != '1) r_score <= r_score + 1'b1;
            end else if (r_sy == YW'(1)) begin
              r_clr <= 1'b1;
            end else begin
              r_sy <= r_sy - 1'b1;
            end
          end
        end
        S_OVER: r_state <= S_OVER;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign piece_x     = r_piece_x;
  assign piece_y     = r_piece_y;
  assign rot         = r_rot;
  assign shape_id    = r_shape;
  assign score       = r_score;
  assign game_over   = (r_state == S_OVER);
  assign move_accept = r_move_accept;
  assign busy        = (r_state != S_FALL);
endmodule

// File: tb/tb_tetris_engine.sv
// Directed bench for tetris_engine: a behavioural board RAM plus
// hand-computed expectations for spawn, moves, landing, line clear and game over.
module tb_tetris_engine;
  localparam int BW = 10;
  localparam int BH = 20;
  localparam int XW = 4;
  localparam int YW = 5;
  localparam int SW = 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          resetn, left_final, right_final, rot_final, tick_gravity;
  logic [XW-1:0] piece_x;
  logic [YW-1:0] piece_y;
  logic [1:0]    rot;
  logic [2:0]    shape_id;
  logic [SW-1:0] score;
  logic          game_over, move_accept, busy;

  tetris_engine_if #(.XW(XW), .YW(YW)) bif ();

  tetris_engine #(
    .BOARD_W(BW), .BOARD_H(BH), .XW(XW), .YW(YW), .NUM_SHAPES(7), .SCORE_W(SW)
  ) dut (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .left_final   (left_final),
    .right_final  (right_final),
    .rot_final    (rot_final),
    .tick_gravity (tick_gravity),
    .board        (bif),
    .piece_x      (piece_x),
    .piece_y      (piece_y),
    .rot          (rot),
    .shape_id     (shape_id),
    .score        (score),
    .game_over    (game_over),
    .move_accept  (move_accept),
    .busy         (busy)
  );

  logic [15:0] mem [32];
  logic        tb_we;
  logic [4:0]  tb_wy;
  logic [15:0] tb_wrow;
  logic        log_clr;
  int          wr_cnt, wr_ones;
  int          n_tests, n_fail;

  assign bif.board_rdata = mem[bif.board_ry][bif.board_rx];

  always @(posedge clk) begin
    if (tb_we) mem[tb_wy] <= tb_wrow;
    else if (bif.board_we) mem[bif.board_wy][bif.board_wx] <= bif.board_wdata;
    if (log_clr) begin
      wr_cnt  <= 0;
      wr_ones <= 0;
    end else if (bif.board_we) begin
      wr_cnt <= wr_cnt + 1;
      if (bif.board_wdata) wr_ones <= wr_ones + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input int y, input logic [15:0] bits);
    tb_we   = 1'b1;
    tb_wy   = 5'(y);
    tb_wrow = bits;
    step();
    tb_we   = 1'b0;
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    left_final = 0; right_final = 0; rot_final = 0; tick_gravity = 0;
    for (int y = 0; y < 32; y++) load_row(y, 16'h0000);
    log_clr = 1'b1;
    step();
    log_clr = 1'b0;
  endtask

  task automatic do_move(input logic l, input logic r, input logic ro, input logic g);
    left_final = l; right_final = r; rot_final = ro; tick_gravity = g;
    step();
    left_final = 0; right_final = 0; rot_final = 0; tick_gravity = 0;
    repeat (4) step();
  endtask

  task automatic wait_fall(input int bound, output int n);
    n = 0;
    while (busy && n < bound) begin
      step();
      n++;
    end
    check("fall_reached", busy, 0);
  endtask

  task automatic drop(output int acc);
    acc = 0;
    for (int k = 0; k < 25; k++) begin
      do_move(0, 0, 0, 1);
      if (!move_accept) break;
      acc++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, pulses, we_seen;
    n_tests = 0; n_fail = 0;
    tb_we = 0; tb_wy = '0; tb_wrow = '0; log_clr = 0;

    // Reset values, spawn pose, FALL after six cycles
    reset_dut();
    check("rst_px", piece_x, 0);
    check("rst_py", piece_y, 0);
    check("rst_rot", rot, 0);
    check("rst_shape", shape_id, 1);
    check("rst_score", score, 0);
    check("rst_over", game_over, 0);
    check("rst_acc", move_accept, 0);
    check("rst_we", bif.board_we, 0);
    resetn = 1'b1;
    step();
    check("spawn_shape", shape_id, 2);
    check("spawn_px", piece_x, 4);
    check("spawn_py", piece_y, 0);
    check("spawn_rot", rot, 0);
    repeat (4) step();
    check("busy_at5", busy, 1);
    step();
    check("busy_at6", busy, 0);

    // Left wall, priority and discarded pulses
    for (int k = 0; k < 3; k++) begin
      do_move(1, 0, 0, 0);
      check("left_acc", move_accept, 1);
    end
    check("left_px", piece_x, 1);
    do_move(1, 0, 0, 0);
    check("wall_acc", move_accept, 0);
    check("wall_px", piece_x, 1);
    check("wall_fall", busy, 0);
    do_move(0, 0, 0, 1);
    check("grav_py", piece_y, 1);
    do_move(0, 1, 0, 0);
    check("right_px", piece_x, 2);
    do_move(1, 0, 1, 0);
    check("prio_acc", move_accept, 1);
    check("prio_px", piece_x, 1);
    check("prio_rot", rot, 0);
    pulses = 0;
    repeat (4) begin
      step();
      pulses += int'(move_accept);
    end
    check("prio_extra_pulses", pulses, 0);
    do_move(0, 0, 1, 0);
    check("rot_rot", rot, 1);
    right_final = 1;
    step();
    right_final = 0;
    left_final = 1;
    step();
    left_final = 0;
    repeat (3) step();
    check("nq_acc", move_accept, 1);
    check("nq_px", piece_x, 2);
    repeat (3) step();
    check("nq_px_later", piece_x, 2);
    check("nq_idle", busy, 0);

    // Landing on the floor, lock writes, rescan and respawn
    reset_dut();
    resetn = 1'b1;
    wait_fall(20, n);
    for (int k = 0; k < 3; k++) do_move(1, 0, 0, 0);
    check("land_px", piece_x, 1);
    drop(acc);
    check("land_drops", acc, 18);
    wait_fall(200, n);
    check("land_cycles", n, 32);
    check("land_wr", wr_cnt, 4);
    check("land_ones", wr_ones, 4);
    check("land_r18", mem[18][BW-1:0], 10'h007);
    check("land_r19", mem[19][BW-1:0], 10'h002);
    check("land_r17", mem[17][BW-1:0], 10'h000);
    check("respawn_px", piece_x, 4);
    check("respawn_py", piece_y, 0);
    check("respawn_score", score, 0);

    // Two full rows: shift, rescan of row 19, row 0 cleared
    reset_dut();
    load_row(19, 16'h01FF);
    load_row(18, 16'h00FF);
    load_row(16, 16'h0008);
    load_row(0, 16'h0001);
    resetn = 1'b1;
    wait_fall(20, n);
    do_move(0, 0, 0, 1);
    do_move(0, 0, 1, 0);
    check("clr_rot", rot, 1);
    for (int k = 0; k < 5; k++) do_move(0, 1, 0, 0);
    check("clr_px", piece_x, 9);
    drop(acc);
    check("clr_drops", acc, 17);
    wait_fall(1000, n);
    check("clr_score", score, 2);
    check("clr_r19", mem[19][BW-1:0], 10'h200);
    check("clr_r18", mem[18][BW-1:0], 10'h008);
    check("clr_r17", mem[17][BW-1:0], 10'h000);
    check("clr_r16", mem[16][BW-1:0], 10'h000);
    check("clr_r2", mem[2][BW-1:0], 10'h001);
    check("clr_r1", mem[1][BW-1:0], 10'h000);
    check("clr_r0", mem[0][BW-1:0], 10'h000);

    // Reset in the middle of LOCK
    reset_dut();
    resetn = 1'b1;
    wait_fall(20, n);
    drop(acc);
    check("abort_drops", acc, 18);
    step();
    step();
    resetn = 1'b0;
    step();
    check("abort_wr", wr_cnt, 2);
    check("abort_r18", mem[18][BW-1:0], 10'h018);
    check("abort_we", bif.board_we, 0);
    check("abort_shape", shape_id, 1);
    check("abort_px", piece_x, 0);

    // Blocked spawn ends the game
    reset_dut();
    load_row(0, 16'h0010);
    resetn = 1'b1;
    we_seen = 0;
    repeat (5) begin
      step();
      we_seen += int'(bif.board_we);
    end
    check("over_at5", game_over, 0);
    step();
    check("over_at6", game_over, 1);
    repeat (20) begin
      left_final = 1;
      tick_gravity = 1;
      step();
      we_seen += int'(bif.board_we);
    end
    left_final = 0;
    tick_gravity = 0;
    check("over_we", we_seen, 0);
    check("over_wr", wr_cnt, 0);
    check("over_hold", game_over, 1);
    check("over_busy", busy, 1);
    check("over_r0", mem[0][BW-1:0], 10'h010);
    resetn = 1'b0;
    step();
    check("over_reset", game_over, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
